// File: rtl/or1k_spr_cfg_port_pkg.sv
// Group-0 SPR map constants, FSM encoding and address decode helpers for or1k_spr_cfg_port.
// Optional ISR write support is selected by OR1K_SPR_ISR_WRITE_EN in the users of this package.
package or1k_spr_cfg_port_pkg;

  localparam logic [4:0]  OR1K_SPR_GROUP_SYS = 5'd0;

  localparam logic [10:0] SPR_VR       = 11'd0;
  localparam logic [10:0] SPR_UPR      = 11'd1;
  localparam logic [10:0] SPR_CPUCFGR  = 11'd2;
  localparam logic [10:0] SPR_DMMUCFGR = 11'd3;
  localparam logic [10:0] SPR_IMMUCFGR = 11'd4;
  localparam logic [10:0] SPR_DCCFGR   = 11'd5;
  localparam logic [10:0] SPR_ICCFGR   = 11'd6;
  localparam logic [10:0] SPR_DCFGR    = 11'd7;
  localparam logic [10:0] SPR_PCCFGR   = 11'd8;
  localparam logic [10:0] SPR_VR2      = 11'd9;
  localparam logic [10:0] SPR_AVR      = 11'd10;
  localparam logic [10:0] SPR_ISR_BASE = 11'd21;
  localparam logic [10:0] SPR_ISR_LAST = 11'd28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RESP   = 2'd2
  } spr_state_e;

  function automatic logic spr_is_cfg(input logic [10:0] idx);
    return idx <= SPR_AVR;
  endfunction

  function automatic logic spr_is_isr(input logic [10:0] idx);
    return (idx >= SPR_ISR_BASE) && (idx <= SPR_ISR_LAST);
  endfunction

  // Indices 11..20 (SR, NPC, EVBAR, ...) belong to other group-0 units.
  function automatic logic spr_hit(input logic [15:0] addr);
    return (addr[15:11] == OR1K_SPR_GROUP_SYS) &&
           (spr_is_cfg(addr[10:0]) || spr_is_isr(addr[10:0]));
  endfunction

endpackage

// File: rtl/or1k_spr_cfg_port_if.sv
// SPR bus between the core (master) and a group-0 SPR slave.
interface or1k_spr_cfg_port_if;
  logic [15:0] spr_bus_addr_i;
  logic        spr_bus_stb_i;
  logic        spr_bus_we_i;
  logic [31:0] spr_bus_dat_i;
  logic        spr_bus_ack_o;
  logic        spr_bus_err_o;
  logic [31:0] spr_bus_dat_o;

  modport master (
    output spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
    input  spr_bus_ack_o, spr_bus_err_o, spr_bus_dat_o
  );

  modport slave (
    input  spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
    output spr_bus_ack_o, spr_bus_err_o, spr_bus_dat_o
  );
endinterface

// File: rtl/or1k_spr_isr_bank.sv
// Writable ISR0..ISR7 storage; only the first NUM registers are built, the rest read 0.
module or1k_spr_isr_bank #(
  parameter int unsigned NUM       = 8,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        we_i,
  input  logic [2:0]  idx_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o
);

  logic [7:0][31:0] isr_val;

  for (genvar gi = 0; gi < 8; gi++) begin : g_isr
    if (gi < NUM) begin : g_impl
      logic [31:0] isr_q;
      always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
          isr_q <= RESET_VAL;
        end else if (we_i && (idx_i == 3'(gi))) begin
          isr_q <= dat_i;
        end
      end
      assign isr_val[gi] = isr_q;
    end else begin : g_absent
      assign isr_val[gi] = 32'h0;
    end
  end

  assign dat_o = isr_val[idx_i];

endmodule

// File: rtl/or1k_spr_cfg_port.sv
// Group-0 SPR slave serving the configuration/version registers and ISR0..ISR7 with a 2-cycle ack.
// Define OR1K_SPR_ISR_WRITE_EN to make the ISRs writable; otherwise they read OPTION_ISR_RESET.
module or1k_spr_cfg_port
  import or1k_spr_cfg_port_pkg::*;
#(
  parameter int unsigned OPTION_ISR_NUM   = 8,
  parameter logic [31:0] OPTION_ISR_RESET = 32'h0
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst_n,
  or1k_spr_cfg_port_if.slave        spr_bus,
  input  logic [31:0]               spr_vr,
  input  logic [31:0]               spr_vr2,
  input  logic [31:0]               spr_upr,
  input  logic [31:0]               spr_cpucfgr,
  input  logic [31:0]               spr_dmmucfgr,
  input  logic [31:0]               spr_immucfgr,
  input  logic [31:0]               spr_dccfgr,
  input  logic [31:0]               spr_iccfgr,
  input  logic [31:0]               spr_dcfgr,
  input  logic [31:0]               spr_pccfgr,
  input  logic [31:0]               spr_avr
);

  spr_state_e       state_q;
  logic [10:0]      idx_q;
  logic             we_q;
  logic             ack_q;
  logic             err_q;
  logic [31:0]      dat_q;
  logic [15:0][31:0] cfg_vec;
  logic [15:0][31:0] snap_q;
  logic [31:0]      resp_dat_d;
  logic             resp_err_d;
  logic [2:0]       isr_n;
  logic [31:0]      isr_rdata;

  always_comb begin
    cfg_vec                   = '0;
    cfg_vec[SPR_VR[3:0]]       = spr_vr;
    cfg_vec[SPR_UPR[3:0]]      = spr_upr;
    cfg_vec[SPR_CPUCFGR[3:0]]  = spr_cpucfgr;
    cfg_vec[SPR_DMMUCFGR[3:0]] = spr_dmmucfgr;
    cfg_vec[SPR_IMMUCFGR[3:0]] = spr_immucfgr;
    cfg_vec[SPR_DCCFGR[3:0]]   = spr_dccfgr;
    cfg_vec[SPR_ICCFGR[3:0]]   = spr_iccfgr;
    cfg_vec[SPR_DCFGR[3:0]]    = spr_dcfgr;
    cfg_vec[SPR_PCCFGR[3:0]]   = spr_pccfgr;
    cfg_vec[SPR_VR2[3:0]]      = spr_vr2;
    cfg_vec[SPR_AVR[3:0]]      = spr_avr;
  end

  // Reads only ever see the flopped copy, never the live configuration vectors.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      snap_q <= '0;
    end else begin
      snap_q <= cfg_vec;
    end
  end

  assign isr_n = 3'(idx_q - SPR_ISR_BASE);

`ifdef OR1K_SPR_ISR_WRITE_EN
  localparam logic ISR_WRITE_ERR = 1'b0;
  logic [31:0] wdat_q;
  logic        isr_we;

  assign isr_we = (state_q == ST_DECODE) && spr_bus.spr_bus_stb_i && we_q && spr_is_isr(idx_q);

  or1k_spr_isr_bank #(
    .NUM       (OPTION_ISR_NUM),
    .RESET_VAL (OPTION_ISR_RESET)
  ) u_isr_bank (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .we_i      (isr_we),
    .idx_i     (isr_n),
    .dat_i     (wdat_q),
    .dat_o     (isr_rdata)
  );
`else
  localparam logic ISR_WRITE_ERR = 1'b1;
  logic [31:0] unused_wdat;

  assign unused_wdat = spr_bus.spr_bus_dat_i;
  assign isr_rdata   = ({29'd0, isr_n} < OPTION_ISR_NUM) ? OPTION_ISR_RESET : 32'h0;
`endif

  always_comb begin
    resp_dat_d = '0;
    resp_err_d = 1'b0;
    if (spr_is_cfg(idx_q)) begin
      if (we_q) begin
        resp_err_d = 1'b1;
      end else begin
        resp_dat_d = snap_q[idx_q[3:0]];
      end
    end else if (we_q) begin
      resp_err_d = ISR_WRITE_ERR;
    end else begin
      resp_dat_d = isr_rdata;
    end
  end

  // ack/err/dat are pulsed for the single RESP cycle and are 0 otherwise.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
`ifdef OR1K_SPR_ISR_WRITE_EN
      wdat_q  <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (spr_bus.spr_bus_stb_i && spr_hit(spr_bus.spr_bus_addr_i)) begin
            state_q <= ST_DECODE;
            idx_q   <= spr_bus.spr_bus_addr_i[10:0];
            we_q    <= spr_bus.spr_bus_we_i;
`ifdef OR1K_SPR_ISR_WRITE_EN
            wdat_q  <= spr_bus.spr_bus_dat_i;
`endif
          end
        end
        ST_DECODE: begin
          if (spr_bus.spr_bus_stb_i) begin
            state_q <= ST_RESP;
            ack_q   <= 1'b1;
            err_q   <= resp_err_d;
            dat_q   <= resp_dat_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spr_bus.spr_bus_ack_o = ack_q;
  assign spr_bus.spr_bus_err_o = err_q;
  assign spr_bus.spr_bus_dat_o = dat_q;

endmodule

// File: tb/tb_or1k_spr_cfg_port.sv
// Directed self-checking bench for or1k_spr_cfg_port (either OR1K_SPR_ISR_WRITE_EN setting).
module tb_or1k_spr_cfg_port;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic [31:0] cfg_in [11];

  int checks = 0;
  int errors = 0;

  or1k_spr_cfg_port_if bus ();

  or1k_spr_cfg_port dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst_n    (cpu_rst_n),
    .spr_bus      (bus),
    .spr_vr       (cfg_in[0]),
    .spr_vr2      (cfg_in[9]),
    .spr_upr      (cfg_in[1]),
    .spr_cpucfgr  (cfg_in[2]),
    .spr_dmmucfgr (cfg_in[3]),
    .spr_immucfgr (cfg_in[4]),
    .spr_dccfgr   (cfg_in[5]),
    .spr_iccfgr   (cfg_in[6]),
    .spr_dcfgr    (cfg_in[7]),
    .spr_pccfgr   (cfg_in[8]),
    .spr_avr      (cfg_in[10])
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: returns ack seen, edges from first sampled stb to ack, data/err at ack,
  // ack one cycle later, and the OR of dat_o while ack was low.
  task automatic bus_op(input logic [15:0] a, input logic w, input logic [31:0] d, input logic poke,
                        output logic acked, output int lat, output logic [31:0] rd,
                        output logic er, output logic ack_after, output logic [31:0] stray);
    acked = 1'b0; lat = 0; rd = '0; er = 1'b0; ack_after = 1'b0; stray = '0;
    @(posedge cpu_clk); #1;
    bus.spr_bus_addr_i = a;
    bus.spr_bus_we_i   = w;
    bus.spr_bus_dat_i  = d;
    bus.spr_bus_stb_i  = 1'b1;
    for (int i = 1; i <= 12 && !acked; i++) begin
      @(negedge cpu_clk);
      if (poke && i == 2) cfg_in[10] = 32'hCAFE_0001;
      if (bus.spr_bus_ack_o) begin
        acked = 1'b1;
        lat   = i - 1;
        rd    = bus.spr_bus_dat_o;
        er    = bus.spr_bus_err_o;
      end else begin
        stray |= bus.spr_bus_dat_o;
      end
    end
    bus.spr_bus_stb_i = 1'b0;
    @(negedge cpu_clk);
    ack_after = bus.spr_bus_ack_o;
    stray    |= bus.spr_bus_dat_o;
  endtask

  logic        acked, er, ack_after, ab_ack;
  int          lat;
  logic [31:0] rd, stray;

  initial begin
    cfg_in[0]  = 32'h1000_0040;  // VR
    cfg_in[1]  = 32'h0000_0619;  // UPR
    cfg_in[2]  = 32'h0000_0020;  // CPUCFGR
    cfg_in[3]  = 32'h0000_0012;  // DMMUCFGR
    cfg_in[4]  = 32'h0000_0013;  // IMMUCFGR
    cfg_in[5]  = 32'h0000_00A3;  // DCCFGR
    cfg_in[6]  = 32'h0000_00A4;  // ICCFGR
    cfg_in[7]  = 32'h0000_0005;  // DCFGR
    cfg_in[8]  = 32'h0000_0006;  // PCCFGR
    cfg_in[9]  = 32'h0400_0000;  // VR2
    cfg_in[10] = 32'h0101_0000;  // AVR
    bus.spr_bus_addr_i = '0;
    bus.spr_bus_we_i   = 1'b0;
    bus.spr_bus_dat_i  = '0;
    bus.spr_bus_stb_i  = 1'b0;
    cpu_rst_n = 1'b0;

    repeat (3) @(negedge cpu_clk);
    check("rst_ack", 32'(bus.spr_bus_ack_o), 32'd0);
    check("rst_err", 32'(bus.spr_bus_err_o), 32'd0);
    check("rst_dat", bus.spr_bus_dat_o, 32'h0);
    cpu_rst_n = 1'b1;
    repeat (2) @(negedge cpu_clk);

    bus_op(16'h0000, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  VR      addr=0000 ack=%0b lat=%0d dat=%h err=%0b", acked, lat, rd, er);
    check("vr_ack", 32'(acked), 32'd1);
    check("vr_lat", lat, 32'd2);
    check("vr_dat", rd, 32'h1000_0040);
    check("vr_err", 32'(er), 32'd0);
    check("vr_ack_once", 32'(ack_after), 32'd0);
    check("vr_dat_idle", stray, 32'h0);

    for (int i = 0; i < 11; i++) begin
      bus_op({5'd0, 11'(i)}, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
      $display("read  cfg     addr=%h ack=%0b dat=%h err=%0b", 16'(i), acked, rd, er);
      check("cfg_ack", 32'(acked), 32'd1);
      check("cfg_dat", rd, cfg_in[i]);
    end

    bus_op(16'h000A, 1'b0, 32'h0, 1'b1, acked, lat, rd, er, ack_after, stray);
    $display("read  AVR     addr=000a ack=%0b dat=%h (input changed mid-cycle)", acked, rd);
    check("avr_snap_ack", 32'(acked), 32'd1);
    check("avr_snap_dat", rd, 32'h0101_0000);
    bus_op(16'h000A, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  AVR     addr=000a ack=%0b dat=%h", acked, rd);
    check("avr_new_dat", rd, 32'hCAFE_0001);

    bus_op(16'h0015, 1'b1, 32'hDEAD_BEEF, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("write ISR0    addr=0015 ack=%0b err=%0b dat=%h", acked, er, rd);
    check("isr_wr_ack", 32'(acked), 32'd1);
    check("isr_wr_dat", rd, 32'h0);
`ifdef OR1K_SPR_ISR_WRITE_EN
    check("isr_wr_err", 32'(er), 32'd0);
`else
    check("isr_wr_err", 32'(er), 32'd1);
`endif
    bus_op(16'h0015, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  ISR0    addr=0015 ack=%0b err=%0b dat=%h", acked, er, rd);
    check("isr_rd_ack", 32'(acked), 32'd1);
    check("isr_rd_err", 32'(er), 32'd0);
`ifdef OR1K_SPR_ISR_WRITE_EN
    check("isr_rd_dat", rd, 32'hDEAD_BEEF);
`else
    check("isr_rd_dat", rd, 32'h0);
`endif
    bus_op(16'h001C, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  ISR7    addr=001c ack=%0b err=%0b dat=%h", acked, er, rd);
    check("isr7_ack", 32'(acked), 32'd1);
    check("isr7_dat", rd, 32'h0);

    bus_op(16'h0002, 1'b1, 32'hFFFF_FFFF, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("write CPUCFGR addr=0002 ack=%0b err=%0b dat=%h", acked, er, rd);
    check("ro_wr_ack", 32'(acked), 32'd1);
    check("ro_wr_err", 32'(er), 32'd1);
    check("ro_wr_dat", rd, 32'h0);
    bus_op(16'h0002, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  CPUCFGR addr=0002 ack=%0b err=%0b dat=%h", acked, er, rd);
    check("ro_rd_dat", rd, 32'h0000_0020);
    check("ro_rd_err", 32'(er), 32'd0);

    bus_op(16'h0011, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  SR      addr=0011 ack=%0b stray=%h", acked, stray);
    check("sr_noack", 32'(acked), 32'd0);
    check("sr_dat0", stray, 32'h0);
    bus_op(16'h0800, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  grp1    addr=0800 ack=%0b stray=%h", acked, stray);
    check("grp1_noack", 32'(acked), 32'd0);
    check("grp1_dat0", stray, 32'h0);
    bus_op(16'h001D, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  idx29   addr=001d ack=%0b stray=%h", acked, stray);
    check("idx29_noack", 32'(acked), 32'd0);

    @(posedge cpu_clk); #1;
    bus.spr_bus_addr_i = 16'h0016;
    bus.spr_bus_we_i   = 1'b1;
    bus.spr_bus_dat_i  = 32'h1234_5678;
    bus.spr_bus_stb_i  = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    bus.spr_bus_stb_i  = 1'b0;
    ab_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clk);
      ab_ack |= bus.spr_bus_ack_o;
    end
    $display("abort write   addr=0016 ack=%0b", ab_ack);
    check("abort_noack", 32'(ab_ack), 32'd0);
    bus_op(16'h0016, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  ISR1    addr=0016 ack=%0b dat=%h", acked, rd);
    check("abort_isr1_ack", 32'(acked), 32'd1);
    check("abort_isr1_dat", rd, 32'h0);

    @(posedge cpu_clk); #1;
    bus.spr_bus_addr_i = 16'h0000;
    bus.spr_bus_we_i   = 1'b0;
    bus.spr_bus_stb_i  = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b0;
    #1;
    check("rstmid_ack", 32'(bus.spr_bus_ack_o), 32'd0);
    check("rstmid_dat", bus.spr_bus_dat_o, 32'h0);
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    $display("reset in DECODE ack=%0b err=%0b dat=%h", bus.spr_bus_ack_o, bus.spr_bus_err_o, bus.spr_bus_dat_o);
    check("rstmid_noack", 32'(bus.spr_bus_ack_o), 32'd0);
    check("rstmid_err", 32'(bus.spr_bus_err_o), 32'd0);
    bus.spr_bus_stb_i = 1'b0;
    cpu_rst_n = 1'b1;
    repeat (2) @(negedge cpu_clk);

    bus_op(16'h0009, 1'b0, 32'h0, 1'b0, acked, lat, rd, er, ack_after, stray);
    $display("read  VR2     addr=0009 ack=%0b lat=%0d dat=%h", acked, lat, rd);
    check("post_rst_ack", 32'(acked), 32'd1);
    check("post_rst_lat", lat, 32'd2);
    check("post_rst_dat", rd, 32'h0400_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
